// File: rtl/unified_mem_pkg.sv
// Shared memory-model types: bus commands, access sizes, defaults and the tag pipeline entry.
package unified_mem_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned MEM_64BIT_LINES_DEF = 8192;
  localparam int unsigned MEM_LATENCY_DEF     = 10;
  localparam int unsigned NUM_TAGS_DEF        = 15;
  localparam int unsigned TAG_W               = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } pipe_entry_t;

  // Byte lanes of a 64-bit line touched by an access of the given size at offset ofs.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] ofs);
    case (size)
      BYTE:    return 8'h01 << ofs;
      HALF:    return 8'h03 << {ofs[2:1], 1'b0};
      WORD:    return 8'h0F << {ofs[2], 2'b00};
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-latency delay line carrying accepted tags and load data to the completion outputs.
module mem_tag_pipe
  import unified_mem_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  pipe_entry_t      in_entry,
  output logic [TAG_W-1:0] out_tag,
  output logic [63:0]      out_data
);

  pipe_entry_t stage_q [DEPTH];

  // Entry loaded at the acceptance edge reaches the outputs DEPTH edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      out_tag  <= '0;
      out_data <= '0;
    end else begin
      stage_q[0] <= in_entry;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      out_tag  <= stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].tag  : '0;
      out_data <= stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].data : '0;
    end
  end

endmodule

// File: rtl/unified_mem.sv
// Tagged fixed-latency unified memory: line storage, tag allocation and byte-lane stores.
module unified_mem
  import unified_mem_pkg::*;
#(
  parameter int unsigned MEM_64BIT_LINES = MEM_64BIT_LINES_DEF,
  parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEF,
  parameter int unsigned NUM_TAGS        = NUM_TAGS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       proc2mem_command,
  input  logic [XLEN-1:0]  proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  input  logic [1:0]       proc2mem_size,
  output logic [TAG_W-1:0] mem2proc_response,
  output logic [63:0]      mem2proc_data,
  output logic [TAG_W-1:0] mem2proc_tag
);

  localparam int unsigned IDX_W = (MEM_64BIT_LINES > 1) ? $clog2(MEM_64BIT_LINES) : 1;

  logic [63:0]       unified_memory [MEM_64BIT_LINES];
  logic [NUM_TAGS:1] busy_q, busy_d;
  logic [IDX_W-1:0]  line_idx;
  logic [TAG_W-1:0]  free_tag;
  logic [7:0]        byte_en;
  logic              is_load, is_store, in_range, aligned, accept;
  pipe_entry_t       pipe_in;

  assign line_idx = proc2mem_addr[3 +: IDX_W];
  assign is_load  = (proc2mem_command == BUS_LOAD);
  assign is_store = (proc2mem_command == BUS_STORE);
  assign in_range = (32'(proc2mem_addr[XLEN-1:3]) < MEM_64BIT_LINES);
  assign byte_en  = byte_mask(proc2mem_size, proc2mem_addr[2:0]);

  always_comb begin
    aligned = 1'b0;
    case (proc2mem_size)
      BYTE:    aligned = 1'b1;
      HALF:    aligned = (proc2mem_addr[0] == 1'b0);
      WORD:    aligned = (proc2mem_addr[1:0] == 2'b00);
      default: aligned = (proc2mem_addr[2:0] == 3'b000);
    endcase
  end

  // Lowest-numbered free tag, zero when every tag is in flight.
  always_comb begin
    free_tag = '0;
    for (int t = int'(NUM_TAGS); t >= 1; t--) begin
      if (!busy_q[t]) free_tag = TAG_W'(t);
    end
  end

  assign mem2proc_response = (reset_n && (is_load || is_store) && in_range && aligned)
                             ? free_tag : '0;
  assign accept = (mem2proc_response != '0);

  // A tag is released at the end of the cycle in which its completion is shown.
  always_comb begin
    busy_d = busy_q;
    for (int t = 1; t <= int'(NUM_TAGS); t++) begin
      if (mem2proc_tag == TAG_W'(t)) busy_d[t] = 1'b0;
      if (accept && (mem2proc_response == TAG_W'(t))) busy_d[t] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // Storage is deliberately not reset so preloaded contents survive reset release.
  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) unified_memory[line_idx][8*b +: 8] <= proc2mem_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept;
    pipe_in.tag   = mem2proc_response;
    if (accept && is_load) pipe_in.data = unified_memory[line_idx];
  end

  mem_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_entry (pipe_in),
    .out_tag  (mem2proc_tag),
    .out_data (mem2proc_data)
  );

endmodule

// File: tb/tb_unified_mem.sv
// Scoreboard bench for unified_mem: latency-10 and latency-14 instances share clock and reset.
module tb_unified_mem;
  import unified_mem_pkg::*;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;

  logic [1:0]  cmd10 = 2'd0, cmd14 = 2'd0, size10 = 2'd0, size14 = 2'd0;
  logic [31:0] addr10 = '0, addr14 = '0;
  logic [63:0] wdata10 = '0, wdata14 = '0;
  logic [3:0]  resp10, resp14, tag10, tag14;
  logic [63:0] rdata10, rdata14;

  exp_t q10[$];
  exp_t q14[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem dut10 (
    .clk(clk), .reset_n(reset_n),
    .proc2mem_command(cmd10), .proc2mem_addr(addr10),
    .proc2mem_data(wdata10), .proc2mem_size(size10),
    .mem2proc_response(resp10), .mem2proc_data(rdata10), .mem2proc_tag(tag10)
  );

  unified_mem #(.MEM_LATENCY(14)) dut14 (
    .clk(clk), .reset_n(reset_n),
    .proc2mem_command(cmd14), .proc2mem_addr(addr14),
    .proc2mem_data(wdata14), .proc2mem_size(size14),
    .mem2proc_response(resp14), .mem2proc_data(rdata14), .mem2proc_tag(tag14)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: a due entry must appear exactly on its cycle, otherwise outputs must be idle.
  always @(negedge clk) begin
    if (q10.size() > 0 && q10[0].due == cyc) begin
      chk("lat10_tag", 64'(tag10), 64'(q10[0].tag));
      chk("lat10_data", rdata10, q10[0].data);
      void'(q10.pop_front());
    end else begin
      chk("lat10_idle", {tag10 == 4'd0, 63'd0}, {1'b1, 63'd0});
      chk("lat10_idle_data", rdata10, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (q14.size() > 0 && q14[0].due == cyc) begin
      chk("lat14_tag", 64'(tag14), 64'(q14[0].tag));
      chk("lat14_data", rdata14, q14[0].data);
      void'(q14.pop_front());
    end else begin
      chk("lat14_idle", {tag14 == 4'd0, 63'd0}, {1'b1, 63'd0});
      chk("lat14_idle_data", rdata14, 64'd0);
    end
  end

  task automatic drive(input bit s14, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [1:0] size);
    if (s14) begin
      cmd14 = cmd; addr14 = addr; wdata14 = data; size14 = size;
    end else begin
      cmd10 = cmd; addr10 = addr; wdata10 = data; size10 = size;
    end
  endtask

  task automatic issue(input bit s14, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [1:0] size,
                       input logic [3:0] exp_resp, input logic [63:0] exp_data,
                       input string name);
    exp_t e;
    @(negedge clk);
    drive(s14, cmd, addr, data, size);
    #1;
    chk(name, 64'(s14 ? resp14 : resp10), 64'(exp_resp));
    if (exp_resp != 4'd0) begin
      e.due  = cyc + 1 + (s14 ? 14 : 10);
      e.tag  = exp_resp;
      e.data = exp_data;
      if (s14) q14.push_back(e);
      else     q10.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, BUS_NONE, 32'd0, 64'd0, BYTE);
    drive(1'b1, BUS_NONE, 32'd0, 64'd0, BYTE);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    dut10.unified_memory[2] = 64'h1122334455667788;
    dut14.unified_memory[2] = 64'h0123456789ABCDEF;
    drive(1'b0, BUS_LOAD, 32'h10, 64'd0, DOUBLE);
    #12;
    chk("reset_resp", 64'(resp10), 64'd0);
    chk("reset_tag", 64'(tag10), 64'd0);
    chk("reset_data", rdata10, 64'd0);
    idle();
    reset_n = 1'b1;

    // Preloaded line read back
    issue(1'b0, BUS_LOAD, 32'h10, 64'd0, DOUBLE, 4'd1, 64'h1122334455667788, "load_preload");
    idle();
    wait_cycles(12);

    // Byte store into lane 3, then merged read
    issue(1'b0, BUS_STORE, 32'h13, 64'h00000000AB000000, BYTE, 4'd1, 64'd0, "store_byte");
    idle();
    chk("store_byte_mem", dut10.unified_memory[2], 64'h11223344AB667788);
    wait_cycles(12);
    issue(1'b0, BUS_LOAD, 32'h10, 64'd0, DOUBLE, 4'd1, 64'h11223344AB667788, "load_merged");
    idle();
    wait_cycles(12);

    // Back-to-back store/load pairs on consecutive cycles
    issue(1'b0, BUS_STORE, 32'h18, 64'hDEADBEEFCAFEF00D, DOUBLE, 4'd1, 64'd0, "b2b_store_d");
    issue(1'b0, BUS_LOAD,  32'h18, 64'd0, DOUBLE, 4'd2, 64'hDEADBEEFCAFEF00D, "b2b_load_d");
    issue(1'b0, BUS_STORE, 32'h16, 64'h5A5A000000000000, HALF, 4'd3, 64'd0, "b2b_store_h");
    issue(1'b0, BUS_LOAD,  32'h10, 64'd0, DOUBLE, 4'd4, 64'h5A5A3344AB667788, "b2b_load_h");
    idle();
    wait_cycles(12);

    // Rejected requests: out of range, misaligned, reserved command
    issue(1'b0, BUS_LOAD,  32'h0001_0000, 64'd0, DOUBLE, 4'd0, 64'd0, "rej_range");
    issue(1'b0, BUS_LOAD,  32'h2, 64'd0, WORD, 4'd0, 64'd0, "rej_word_misalign");
    issue(1'b0, BUS_STORE, 32'h11, 64'hFFFFFFFFFFFFFFFF, HALF, 4'd0, 64'd0, "rej_half_misalign");
    issue(1'b0, 2'd3, 32'h10, 64'd0, DOUBLE, 4'd0, 64'd0, "rej_cmd3");
    idle();
    wait_cycles(14);
    chk("rej_mem_line2", dut10.unified_memory[2], 64'h5A5A3344AB667788);

    // Reset with three loads outstanding
    issue(1'b0, BUS_LOAD, 32'h10, 64'd0, DOUBLE, 4'd1, 64'h5A5A3344AB667788, "rst_pre_1");
    issue(1'b0, BUS_LOAD, 32'h18, 64'd0, DOUBLE, 4'd2, 64'hDEADBEEFCAFEF00D, "rst_pre_2");
    issue(1'b0, BUS_LOAD, 32'h08, 64'd0, DOUBLE, 4'd3, 64'd0, "rst_pre_3");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    q10.delete();
    #1;
    chk("rst_resp", 64'(resp10), 64'd0);
    chk("rst_tag", 64'(tag10), 64'd0);
    chk("rst_data", rdata10, 64'd0);
    wait_cycles(2);
    drive(1'b0, BUS_NONE, 32'd0, 64'd0, BYTE);
    reset_n = 1'b1;
    wait_cycles(16);
    chk("rst_mem_line2", dut10.unified_memory[2], 64'h5A5A3344AB667788);
    chk("rst_mem_line3", dut10.unified_memory[3], 64'hDEADBEEFCAFEF00D);

    // Tag exhaustion at latency 14: tags 1..15, one stall, then tag 1 reused
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, BUS_LOAD, 32'h10, 64'd0, DOUBLE,
            (i < 15) ? 4'(i + 1) : ((i == 15) ? 4'd0 : 4'd1),
            64'h0123456789ABCDEF, $sformatf("exhaust_%0d", i));
    end
    idle();
    wait_cycles(32);

    chk("q10_drained", 64'(q10.size()), 64'd0);
    chk("q14_drained", 64'(q14.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
